// File: rtl/multicycle_controller_pkg.sv
// Shared definitions for the multicycle controller and its datapath:
// FSM state type, opcode constants, ALU operation codes, mux-select codes
// and the packed bundle of registered control outputs.
package multicycle_controller_pkg;

  typedef enum logic [3:0] {
    S_RST,
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECR,
    S_EXECI,
    S_ALUWB,
    S_BRANCH,
    S_JAL,
    S_HALT
  } state_e;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  // ALUOp: how the ALU decoder chooses the operation
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_A     = 2'b10;

  localparam logic [1:0] SRCB_WD   = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  typedef struct packed {
    logic       pc_write;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] imm_src;
    logic [1:0] alu_op;
    logic       branch;
    logic       halted;
    logic       retire;
  } ctrl_t;

  function automatic logic is_legal(input logic [6:0] op);
    return op inside {OP_LW, OP_SW, OP_R, OP_I, OP_BR, OP_JAL};
  endfunction

endpackage

// File: rtl/multicycle_controller_aludec.sv
// ALU decoder: maps ALUOp plus the latched instruction fields to ALUControl.
// Ports:
//   op_i, funct3_i, funct7b5_i  latched instruction fields
//   alu_op_i                    ALUOp from the FSM
//   alu_control_o               ALU operation code
module multicycle_controller_aludec
  import multicycle_controller_pkg::*;
(
  input  logic [6:0] op_i,
  input  logic [2:0] funct3_i,
  input  logic       funct7b5_i,
  input  logic [1:0] alu_op_i,
  output logic [2:0] alu_control_o
);

  always_comb begin
    alu_control_o = ALU_ADD;
    case (alu_op_i)
      ALUOP_SUB: alu_control_o = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3_i)
          // instr[30] only selects sub for register-register ops; addi ignores it
          3'b000:  alu_control_o = (op_i == OP_R && funct7b5_i) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_control_o = ALU_SLT;
          3'b110:  alu_control_o = ALU_OR;
          3'b111:  alu_control_o = ALU_AND;
          default: alu_control_o = ALU_ADD;
        endcase
      end
      default: alu_control_o = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RISC-V style controller: Moore FSM with registered outputs.
// Ports:
//   clk, reset (async, active-low)
//   op, funct3, funct7b5   instruction fields from memory read data
//   Zero                   ALU zero flag (used in BRANCH)
//   PCWrite..RegWrite      datapath strobes/selects
//   ResultSrc..ImmSrc      datapath mux selects
//   ALUControl             ALU operation
//   halted, retire         status
//
// state    | meaning
// ---------+-------------------------------------------
// RST      | one idle cycle after reset release
// FETCH    | read instr, latch fields, PC <= PC+4
// DECODE   | read regs, compute branch/jal target
// MEMADR   | compute load/store address
// MEMREAD  | read data memory
// MEMWB    | write load data to register file
// MEMWRITE | write data memory
// EXECR    | register-register ALU op
// EXECI    | register-immediate ALU op
// ALUWB    | write ALU result to register file
// BRANCH   | compare, conditionally take branch
// JAL      | PC <= target, compute link address
// HALT     | stopped on illegal opcode
module multicycle_controller
  import multicycle_controller_pkg::*;
#(
  parameter bit HALT_ON_ILLEGAL = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Zero,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ImmSrc,
  output logic [2:0] ALUControl,
  output logic       halted,
  output logic       retire
);

  state_e     state_q, state_d;
  ctrl_t      ctrl_q, ctrl_d;
  logic [6:0] op_q, op_n;
  logic [2:0] funct3_q, funct3_n;
  logic       funct7b5_q, funct7b5_n;
  logic       rst_done_q;

  // Outputs are registered from the next state, so decode must see the
  // field values that will be latched at this edge.
  always_comb begin
    op_n       = (state_q == S_FETCH) ? op       : op_q;
    funct3_n   = (state_q == S_FETCH) ? funct3   : funct3_q;
    funct7b5_n = (state_q == S_FETCH) ? funct7b5 : funct7b5_q;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      // rst_done_q holds RST for one full cycle after release
      S_RST:      if (rst_done_q) state_d = S_FETCH;
      S_FETCH:    state_d = S_DECODE;
      S_DECODE: begin
        case (op_q)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECR;
          OP_I:         state_d = S_EXECI;
          OP_BR:        state_d = S_BRANCH;
          OP_JAL:       state_d = S_JAL;
          default:      state_d = HALT_ON_ILLEGAL ? S_HALT : S_FETCH;
        endcase
      end
      S_MEMADR:   state_d = (op_q == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  state_d = S_MEMWB;
      S_EXECR, S_EXECI, S_JAL: state_d = S_ALUWB;
      S_MEMWB, S_MEMWRITE, S_ALUWB, S_BRANCH: state_d = S_FETCH;
      S_HALT:     state_d = S_HALT;
      default:    state_d = S_RST;
    endcase
  end

  always_comb begin
    ctrl_d = '0;
    case (state_d)
      S_FETCH: begin
        ctrl_d.ir_write   = 1'b1;
        ctrl_d.pc_write   = 1'b1;
        ctrl_d.alu_src_a  = SRCA_PC;
        ctrl_d.alu_src_b  = SRCB_FOUR;
        ctrl_d.result_src = RES_ALURESULT;
      end
      S_DECODE: begin
        ctrl_d.alu_src_a = SRCA_OLDPC;
        ctrl_d.alu_src_b = SRCB_IMM;
        ctrl_d.imm_src   = (op_n == OP_JAL) ? IMM_J : IMM_B;
        ctrl_d.retire    = !HALT_ON_ILLEGAL && !is_legal(op_n);
      end
      S_MEMADR: begin
        ctrl_d.alu_src_a = SRCA_A;
        ctrl_d.alu_src_b = SRCB_IMM;
        ctrl_d.imm_src   = (op_n == OP_SW) ? IMM_S : IMM_I;
      end
      S_MEMREAD: ctrl_d.adr_src = 1'b1;
      S_MEMWB: begin
        ctrl_d.result_src = RES_DATA;
        ctrl_d.reg_write  = 1'b1;
        ctrl_d.retire     = 1'b1;
      end
      S_MEMWRITE: begin
        ctrl_d.adr_src   = 1'b1;
        ctrl_d.mem_write = 1'b1;
        ctrl_d.retire    = 1'b1;
      end
      S_EXECR: begin
        ctrl_d.alu_src_a = SRCA_A;
        ctrl_d.alu_src_b = SRCB_WD;
        ctrl_d.alu_op    = ALUOP_FUNCT;
      end
      S_EXECI: begin
        ctrl_d.alu_src_a = SRCA_A;
        ctrl_d.alu_src_b = SRCB_IMM;
        ctrl_d.imm_src   = IMM_I;
        ctrl_d.alu_op    = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        ctrl_d.reg_write = 1'b1;
        ctrl_d.retire    = 1'b1;
      end
      S_BRANCH: begin
        ctrl_d.alu_src_a = SRCA_A;
        ctrl_d.alu_src_b = SRCB_WD;
        ctrl_d.alu_op    = ALUOP_SUB;
        ctrl_d.branch    = 1'b1;
        ctrl_d.retire    = 1'b1;
      end
      S_JAL: begin
        ctrl_d.alu_src_a = SRCA_OLDPC;
        ctrl_d.alu_src_b = SRCB_FOUR;
        ctrl_d.pc_write  = 1'b1;
      end
      S_HALT:  ctrl_d.halted = 1'b1;
      default: ctrl_d = '0;
    endcase
  end

  // Async clear drops every strobe the moment reset asserts.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_RST;
      ctrl_q     <= '0;
      op_q       <= '0;
      funct3_q   <= '0;
      funct7b5_q <= 1'b0;
      rst_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ctrl_q     <= ctrl_d;
      op_q       <= op_n;
      funct3_q   <= funct3_n;
      funct7b5_q <= funct7b5_n;
      rst_done_q <= 1'b1;
    end
  end

  multicycle_controller_aludec aludec (
    .op_i         (op_q),
    .funct3_i     (funct3_q),
    .funct7b5_i   (funct7b5_q),
    .alu_op_i     (ctrl_q.alu_op),
    .alu_control_o(ALUControl)
  );

  // Zero is only valid during the BRANCH cycle itself, so the taken
  // decision cannot be registered.
  assign PCWrite   = ctrl_q.pc_write |
                     (ctrl_q.branch & (((funct3_q == 3'b000) & Zero) |
                                       ((funct3_q == 3'b001) & ~Zero)));
  assign AdrSrc    = ctrl_q.adr_src;
  assign MemWrite  = ctrl_q.mem_write;
  assign IRWrite   = ctrl_q.ir_write;
  assign RegWrite  = ctrl_q.reg_write;
  assign ResultSrc = ctrl_q.result_src;
  assign ALUSrcA   = ctrl_q.alu_src_a;
  assign ALUSrcB   = ctrl_q.alu_src_b;
  assign ImmSrc    = ctrl_q.imm_src;
  assign halted    = ctrl_q.halted;
  assign retire    = ctrl_q.retire;

endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 Parameter HALT_ON_ILLEGAL, default 1; 1 = unsupported opcode enters HALT, 0 = it is retired as a NOP.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 op  input  7  opcode field of the instruction-memory read data.
REQ-005 funct3  input  3  instr[14:12] of the read data.
REQ-006 funct7b5  input  1  instr[30] of the read data.
REQ-007 Zero  input  1  ALU zero flag.
REQ-008 PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite  output  1 each  datapath strobes and selects.
REQ-009 ResultSrc, ALUSrcA, ALUSrcB, ImmSrc  output  2 each  datapath mux selects.
REQ-010 ALUControl  output  3  ALU operation.
REQ-011 halted  output  1  high while in HALT.
REQ-012 retire  output  1  one-cycle pulse in the last cycle of each instruction.

Function
REQ-013 Moore FSM with states RST, FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH, JAL, HALT.
REQ-014 op, funct3 and funct7b5 are latched internally in FETCH (the IRWrite cycle); all later decode uses the latched copies only.
REQ-015 Opcodes: lw 0000011, sw 0100011, R-type 0110011, I-ALU 0010011, branch 1100011, jal 1101111; any other opcode is illegal.
REQ-016 Transitions:
- RST->FETCH
- FETCH->DECODE
- DECODE->MEMADR for lw/sw, EXECR, EXECI, BRANCH or JAL by opcode; illegal -> HALT (HALT_ON_ILLEGAL=1) or FETCH (=0)
- MEMADR->MEMREAD for lw, MEMWRITE for sw
- MEMREAD->MEMWB
- EXECR/EXECI/JAL->ALUWB
- MEMWB/MEMWRITE/ALUWB/BRANCH->FETCH
- HALT->HALT
REQ-017 Required cycle counts: lw 5, sw 4, R 4, I 4, branch 3, jal 4, illegal NOP 2.
REQ-018 Encodings:
- ALUSrcA: 00 PC, 01 OldPC, 10 A
- ALUSrcB: 00 WriteData, 01 ImmExt, 10 constant 4
- ResultSrc: 00 ALUOut, 01 data, 10 ALUResult
- ImmSrc: 00 I, 01 S, 10 B, 11 J
REQ-019 ALUControl: 000 add, 001 sub, 010 and, 011 or, 101 slt.
REQ-020 Outputs per state; every signal not listed is 0.
- FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=00, ALUSrcB=10, add, ResultSrc=10, PCWrite=1
- DECODE: ALUSrcA=01, ALUSrcB=01, add, ImmSrc=11 if latched op is jal, else 10
- MEMADR: ALUSrcA=10, ALUSrcB=01, add, ImmSrc=00 for lw, 01 for sw
- MEMREAD: ResultSrc=00, AdrSrc=1
- MEMWB: ResultSrc=01, RegWrite=1
- MEMWRITE: ResultSrc=00, AdrSrc=1, MemWrite=1
- EXECR: ALUSrcA=10, ALUSrcB=00, ALUOp=funct
- EXECI: ALUSrcA=10, ALUSrcB=01, ImmSrc=00, ALUOp=funct
- ALUWB: ResultSrc=00, RegWrite=1
- BRANCH: ALUSrcA=10, ALUSrcB=00, sub, ResultSrc=00, PCWrite=(funct3==000 & Zero) | (funct3==001 & !Zero)
- JAL: ALUSrcA=01, ALUSrcB=10, add, ResultSrc=00, PCWrite=1
REQ-021 Funct decode: funct3 000 -> sub if latched op is R-type and funct7b5=1, else add; 010 slt; 110 or; 111 and; all other funct3 -> add.
REQ-022 A branch with funct3 other than 000/001 never asserts PCWrite.
REQ-023 retire is high in MEMWB, MEMWRITE, ALUWB and BRANCH, and in DECODE for an illegal opcode when HALT_ON_ILLEGAL=0.
REQ-024 PCWrite, MemWrite, IRWrite and RegWrite are never high in the same cycle as one another, except PCWrite with IRWrite in FETCH.

Reset
REQ-025 While reset=0, the state is RST, all outputs are 0 and the latched fields are 0, independent of clk.
REQ-026 Reset asserted mid-instruction aborts it immediately: no write strobe is high in the cycle of assertion, and none after it.
REQ-027 The first FETCH occurs on the second rising edge after reset deasserts (one RST cycle).

Structure
REQ-028 The state typedef, opcode constants, ALUControl codes and mux-select codes live in a shared package used by the controller and the datapath.
REQ-029 ALU decode (latched op, funct3, funct7b5, ALUOp -> ALUControl) is a separate combinational sub-module, aludec; everything else is in the FSM.

Verification
REQ-030 Release reset -> one RST cycle, then FETCH with PCWrite=1 and IRWrite=1; all strobes stay 0 before that.
REQ-031 lw 0x00002083 -> 5 states FETCH,DECODE,MEMADR,MEMREAD,MEMWB; RegWrite=1, ResultSrc=01 in MEMWB; retire pulses once.
REQ-032 sw 0x00112023 -> MemWrite=1 in exactly one cycle (cycle 4), AdrSrc=1, RegWrite never set.
REQ-033 R-type sub 0x40208033 -> ALUControl=001 in EXECR; same encoding with instr[30]=0 (add) -> 000.
REQ-034 beq 0x00000463 with Zero=1 -> PCWrite=1 in cycle 3; Zero=0 -> PCWrite=0; bne (funct3=001) gives the opposite.
REQ-035 Opcode 0x7F with HALT_ON_ILLEGAL=1 -> HALT, halted=1, no further strobes; reset asserted during MEMWRITE -> MemWrite drops in the same cycle, with no clk edge required.
